// File: rtl/fdivsqrt_otfc4.sv
// Radix-4 on-the-fly conversion and iteration control for the fdivsqrt unit.
// Takes one signed digit per cycle and keeps the result U and its decrement
// UM = U - 1 ulp, both in plain two's complement. Because of this, no final
// carry-propagate add is needed. It also produces the j1/j2 iteration flags
// used by digit selection.
module fdivsqrt_otfc4 #(
    parameter int unsigned MAXSTEPS = 28,
    parameter int unsigned CW       = $clog2(MAXSTEPS + 1),
    parameter int unsigned UW       = 2 * MAXSTEPS + 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [CW-1:0] Nsteps,
    input  logic          SqrtE,
    input  logic          flush,
    input  logic [3:0]    udigit,
    output logic          j1,
    output logic          j2,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [UW-1:0] U,
    output logic [UW-1:0] UM
);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] neff_q, neff_d;
    logic [UW-1:0] u_q, u_d;
    logic [UW-1:0] um_q, um_d;
    logic          err_q, err_d;

    logic [CW-1:0] nsteps_clamped;
    logic          multi_hot;
    logic [3:0]    dsel;

    // Clamp the requested step count to what the result register can hold.
    always_comb begin
        nsteps_clamped = (Nsteps > CW'(MAXSTEPS)) ? CW'(MAXSTEPS) : Nsteps;
    end

    // Detect an illegal digit; such a digit is treated as zero.
    always_comb begin
        multi_hot = (udigit & (udigit - 4'd1)) != 4'd0;
        dsel      = multi_hot ? 4'b0000 : udigit;
    end

    // Next state: sequencing, U/UM conversion, and flush override.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        neff_d  = neff_q;
        u_d     = u_q;
        um_d    = um_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    neff_d = nsteps_clamped;
                    err_d  = 1'b0;
                    cnt_d  = '0;
                    // SqrtE only selects the initial value, so it is not stored.
                    // Sqrt starts the root at 1.
                    // Divide starts U at 0, so UM is -1.
                    u_d     = SqrtE ? {{(UW-1){1'b0}}, 1'b1} : '0;
                    um_d    = SqrtE ? '0 : '1;
                    state_d = (nsteps_clamped == '0) ? StDone : StIter;
                end
            end
            StIter: begin
                if (multi_hot) begin
                    err_d = 1'b1;
                end
                unique case (dsel)
                    4'b1000: begin // +2
                        u_d  = {u_q[UW-3:0], 2'b10};
                        um_d = {u_q[UW-3:0], 2'b01};
                    end
                    4'b0100: begin // +1
                        u_d  = {u_q[UW-3:0], 2'b01};
                        um_d = {u_q[UW-3:0], 2'b00};
                    end
                    4'b0010: begin // -1
                        u_d  = {um_q[UW-3:0], 2'b11};
                        um_d = {um_q[UW-3:0], 2'b10};
                    end
                    4'b0001: begin // -2
                        u_d  = {um_q[UW-3:0], 2'b10};
                        um_d = {um_q[UW-3:0], 2'b01};
                    end
                    default: begin // 0 (also used for an illegal digit)
                        u_d  = {u_q[UW-3:0], 2'b00};
                        um_d = {um_q[UW-3:0], 2'b11};
                    end
                endcase
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == neff_q - CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Flush beats everything, including a simultaneous start.
        // The sticky error flag is left unchanged.
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            u_d     = '0;
            um_d    = '0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            neff_q  <= '0;
            u_q     <= '0;
            um_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            neff_q  <= neff_d;
            u_q     <= u_d;
            um_q    <= um_d;
            err_q   <= err_d;
        end
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy = (state_q == StIter);
        done = (state_q == StDone);
        j1   = busy && (cnt_q == '0);
        j2   = busy && (cnt_q == CW'(1));
        err  = err_q;
        U    = u_q;
        UM   = um_q;
    end

endmodule

// File: tb/tb_fdivsqrt_otfc4.sv
// Randomised self-checking bench for fdivsqrt_otfc4. The reference value is
// built with ordinary integer arithmetic: U = sum of digit * 4^k, and UM = U - 1.
module tb_fdivsqrt_otfc4;

    localparam int unsigned MAXSTEPS = 28;
    localparam int unsigned CW       = $clog2(MAXSTEPS + 1);
    localparam int unsigned UW       = 2 * MAXSTEPS + 2;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [CW-1:0] Nsteps;
    logic          SqrtE;
    logic          flush;
    logic [3:0]    udigit;
    logic          j1, j2, busy, done, err;
    logic [UW-1:0] U, UM;

    int n_checks;
    int n_errors;

    // Per-step stimulus: digit value, and an illegal code (0 = legal digit).
    int         digs [64];
    logic [3:0] badc [64];

    fdivsqrt_otfc4 #(.MAXSTEPS(MAXSTEPS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .Nsteps  (Nsteps),
        .SqrtE   (SqrtE),
        .flush   (flush),
        .udigit  (udigit),
        .j1      (j1),
        .j2      (j2),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .U       (U),
        .UM      (UM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] enc_digit(input int d);
        case (d)
            2:       return 4'b1000;
            1:       return 4'b0100;
            -1:      return 4'b0010;
            -2:      return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [63:0] mask_uw(input longint v);
        logic [63:0] m;
        m = (64'd1 << UW) - 64'd1;
        return 64'(v) & m;
    endfunction

    // Run one operation using digs/badc; checks every cycle through done.
    task automatic run_op(input bit sq, input int ns);
        longint val;
        bit     exp_err;
        int     neff;
        int     d;
        neff    = (ns > int'(MAXSTEPS)) ? int'(MAXSTEPS) : ns;
        val     = sq ? 64'sd1 : 64'sd0;
        exp_err = 1'b0;
        start   = 1'b1;
        SqrtE   = sq;
        Nsteps  = CW'(ns);
        udigit  = 4'b0000;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < neff; k++) begin
            check_val("busy", 64'(busy), 64'd1);
            check_val("done_in_iter", 64'(done), 64'd0);
            check_val("j1", 64'(j1), 64'(k == 0));
            check_val("j2", 64'(j2), 64'(k == 1));
            check_val("U_step", 64'(U), mask_uw(val));
            check_val("UM_step", 64'(UM), mask_uw(val - 1));
            if (badc[k] != 4'b0000) begin
                udigit  = badc[k];
                exp_err = 1'b1;
                d       = 0;
            end else begin
                d      = digs[k];
                udigit = enc_digit(d);
            end
            val = val * 4 + longint'(d);
            @(posedge clk); #1;
        end
        // Garbage digit in DONE must be ignored.
        udigit = 4'b1111;
        check_val("done", 64'(done), 64'd1);
        check_val("busy_done", 64'(busy), 64'd0);
        check_val("j1_done", 64'(j1), 64'd0);
        check_val("U", 64'(U), mask_uw(val));
        check_val("UM", 64'(UM), mask_uw(val - 1));
        check_val("err", 64'(err), 64'(exp_err));
        @(posedge clk); #1;
        udigit = 4'b0000;
        check_val("done_pulse", 64'(done), 64'd0);
        check_val("busy_idle", 64'(busy), 64'd0);
        check_val("U_hold", 64'(U), mask_uw(val));
        check_val("UM_hold", 64'(UM), mask_uw(val - 1));
        check_val("err_hold", 64'(err), 64'(exp_err));
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 64; k++) begin
            digs[k] = 0;
            badc[k] = 4'b0000;
        end
    endtask

    initial begin
        logic [3:0] bad_list [5];
        bad_list[0] = 4'b1100;
        bad_list[1] = 4'b1010;
        bad_list[2] = 4'b0011;
        bad_list[3] = 4'b1111;
        bad_list[4] = 4'b0110;
        n_checks = 0;
        n_errors = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        Nsteps   = '0;
        SqrtE    = 1'b0;
        flush    = 1'b0;
        udigit   = 4'b0000;
        clear_stim();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_U", 64'(U), 64'd0);
        check_val("rst_UM", 64'(UM), 64'd0);
        check_val("rst_flags", {59'd0, j1, j2, busy, done, err}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Divide +1,+2,-1 -> 23/22
        clear_stim();
        digs[0] = 1; digs[1] = 2; digs[2] = -1;
        run_op(1'b0, 3);
        check_val("dir_div_U", 64'(U), 64'd23);

        // Sqrt -2,+1 -> 9/8
        clear_stim();
        digs[0] = -2; digs[1] = 1;
        run_op(1'b1, 2);
        check_val("dir_sqrt_U", 64'(U), 64'd9);

        // Divide single -1 -> all ones
        clear_stim();
        digs[0] = -1;
        run_op(1'b0, 1);

        // Zero steps, and clamped counts above MAXSTEPS
        clear_stim();
        run_op(1'b0, 0);
        check_val("n0_UM", 64'(UM), mask_uw(-1));
        for (int k = 0; k < 64; k++) digs[k] = int'($urandom_range(0, 4)) - 2;
        run_op(1'b1, 31);
        run_op(1'b0, 29);

        // Illegal 1100 treated as zero; err cleared by the next start
        clear_stim();
        digs[0] = 1; badc[1] = 4'b1100; digs[2] = 2;
        run_op(1'b0, 3);
        clear_stim();
        digs[0] = 2;
        run_op(1'b0, 1);

        // Flush with the second digit, together with a start that must be dropped
        start = 1'b1; SqrtE = 1'b0; Nsteps = CW'(4);
        @(posedge clk); #1;
        start  = 1'b0;
        udigit = enc_digit(1);
        @(posedge clk); #1;
        flush  = 1'b1;
        start  = 1'b1;
        udigit = enc_digit(2);
        @(posedge clk); #1;
        flush  = 1'b0;
        start  = 1'b0;
        udigit = 4'b0000;
        check_val("flush_busy", 64'(busy), 64'd0);
        check_val("flush_U", 64'(U), 64'd0);
        check_val("flush_UM", 64'(UM), 64'd0);
        for (int k = 0; k < 5; k++) begin
            check_val("flush_nodone", {62'd0, busy, done}, 64'd0);
            @(posedge clk); #1;
        end

        // Reset during an operation
        start = 1'b1; SqrtE = 1'b1; Nsteps = CW'(5);
        @(posedge clk); #1;
        start  = 1'b0;
        udigit = enc_digit(2);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        udigit  = 4'b0000;
        check_val("midrst_U", 64'(U), 64'd0);
        check_val("midrst_flags", {59'd0, j1, j2, busy, done, err}, 64'd0);

        // Random operations
        for (int t = 0; t < 40; t++) begin
            clear_stim();
            for (int k = 0; k < 64; k++) begin
                digs[k] = int'($urandom_range(0, 4)) - 2;
                if ($urandom_range(0, 11) == 0) badc[k] = bad_list[$urandom_range(0, 4)];
            end
            run_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
